// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART byte FIFO.
package uart_fifo_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FIFO_W = 2;

  // Sticky debug error flags
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;
endpackage

// File: rtl/uart_fifo_if.sv
// Host-side handshake bundle of the UART FIFO. The master drives requests and
// the slave (the FIFO) returns head data and status.
interface uart_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_W
);
  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic              rd;
  logic              clr_err;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, w_data, rd, clr_err,
    input  r_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr, w_data, rd, clr_err,
    output r_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/uart_fifo_reg_file.sv
// Storage for the FIFO: one synchronous write port, one asynchronous read
// port so the head word falls through without a read cycle. Not reset.
module fifo_reg_file
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO between host bus and UART core.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// all status comes from registered pointers, never from wr/rd directly.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_W
) (
  input  logic       clk,
  input  logic       reset,
  uart_fifo_if.slave bus
);
  logic [ADDR_W:0]   wptr, rptr;
  logic [DATA_W-1:0] head;
  logic              empty, full;
  logic              do_wr, do_rd;
  logic              ovf_evt, unf_evt;
  fifo_err_t         err;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                 (wptr[ADDR_W] != rptr[ADDR_W]);

  // When full, a concurrent pop frees the head slot, which the write reuses.
  assign do_wr   = bus.wr & (~full | bus.rd);
  assign do_rd   = bus.rd & ~empty;
  assign ovf_evt = bus.wr & full & ~bus.rd;
  assign unf_evt = bus.rd & empty;

  fifo_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (bus.w_data),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (head)
  );

  // Pointer advance; reset discards contents in one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags; a fresh error beats clr_err in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= '0;
    end else begin
      if (ovf_evt)          err.overflow  <= 1'b1;
      else if (bus.clr_err) err.overflow  <= 1'b0;
      if (unf_evt)          err.underflow <= 1'b1;
      else if (bus.clr_err) err.underflow <= 1'b0;
    end
  end

  assign bus.r_data    = empty ? '0 : head;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = wptr - rptr;
  assign bus.overflow  = err.overflow;
  assign bus.underflow = err.underflow;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed table-driven bench for uart_fifo (depth 4, 8-bit words).
module tb_uart_fifo;
  import uart_fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_fifo_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  uart_fifo #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n, wr, rd, clr;
    logic [7:0] wd;
    logic [7:0] r;
    logic       e, f;
    logic [2:0] c;
    logic       ov, un;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic wr, logic rd, logic clr,
                              logic [7:0] wd, logic [7:0] r, logic e, logic f,
                              logic [2:0] c, logic ov, logic un);
    vec_t v;
    v.rst_n = rst_n; v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
    v.r = r; v.e = e; v.f = f; v.c = c; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample all outputs 1 time unit after the edge
  task automatic step(string tag, vec_t v);
    reset       = v.rst_n;
    bus.wr      = v.wr;
    bus.rd      = v.rd;
    bus.clr_err = v.clr;
    bus.w_data  = v.wd;
    @(posedge clk);
    #1;
    chk({tag, ".r_data"},    32'(bus.r_data),    32'(v.r));
    chk({tag, ".empty"},     32'(bus.empty),     32'(v.e));
    chk({tag, ".full"},      32'(bus.full),      32'(v.f));
    chk({tag, ".count"},     32'(bus.count),     32'(v.c));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(v.ov));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(v.un));
  endtask

  initial begin
    reset = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0; bus.w_data = '0;

    //            rst wr rd clr wd     r_data e  f  cnt ov un
    // reset held with wr=1: nothing stored
    tbl.push_back(mk(0, 1, 0, 0, 8'h99, 8'h00, 1, 0, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h98, 8'h00, 1, 0, 3'd0, 0, 0));
    // fill
    tbl.push_back(mk(1, 1, 0, 0, 8'hA1, 8'hA1, 0, 0, 3'd1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'hB2, 8'hA1, 0, 0, 3'd2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'hC3, 8'hA1, 0, 0, 3'd3, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'hD4, 8'hA1, 0, 1, 3'd4, 0, 0));
    // overflow: 0xEE dropped, then cleared
    tbl.push_back(mk(1, 1, 0, 0, 8'hEE, 8'hA1, 0, 1, 3'd4, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'hA1, 0, 1, 3'd4, 0, 0));
    // wr+rd at full: A1 out, 0x77 in, count stays 4, no overflow
    tbl.push_back(mk(1, 1, 1, 0, 8'h77, 8'hB2, 0, 1, 3'd4, 0, 0));
    // drain: B2 C3 D4 77 (0xEE never appears)
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'hC3, 0, 0, 3'd3, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'hD4, 0, 0, 3'd2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h77, 0, 0, 3'd1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0));
    // underflow with simultaneous write: write still accepted
    tbl.push_back(mk(1, 1, 1, 0, 8'h55, 8'h55, 0, 0, 3'd1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 3'd0, 0, 1));
    // clr_err with a new underflow in the same cycle: flag stays set
    tbl.push_back(mk(1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 3'd0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0));

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    // Streaming push/pop: ten words, pointers wrap the 4-entry array twice
    for (int k = 0; k < 10; k++) begin
      step($sformatf("s%0d.push", k), mk(1, 1, 0, 0, 8'(8'h30 + k), 8'(8'h30 + k), 0, 0, 3'd1, 0, 0));
      step($sformatf("s%0d.pop", k),  mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0));
    end

    // wr+rd at count 1: head replaced, count unchanged
    step("m.push", mk(1, 1, 0, 0, 8'h40, 8'h40, 0, 0, 3'd1, 0, 0));
    step("m.both", mk(1, 1, 1, 0, 8'h41, 8'h41, 0, 0, 3'd1, 0, 0));
    step("m.push2", mk(1, 1, 0, 0, 8'h42, 8'h41, 0, 0, 3'd2, 0, 0));
    // mid-stream reset empties in one cycle despite wr=1
    step("m.reset", mk(0, 1, 0, 0, 8'h43, 8'h00, 1, 0, 3'd0, 0, 0));
    step("m.after", mk(1, 1, 0, 0, 8'h5A, 8'h5A, 0, 0, 3'd1, 0, 0));
    step("m.pop",   mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
